// File: rtl/rgen_pkg.sv
// Shared types and constants for the register-block response path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rgen_pkg;

  // Bit positions inside the 3-bit response status.
  localparam int SLAVE_ERROR  = 0;
  localparam int DECODE_ERROR = 1;
  localparam int EXOKAY       = 2;

  typedef logic [2:0] rgen_status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } rgen_response_state_t;

  // Build a status word; exclusive-okay is never reported by this block.
  function automatic rgen_status_t rgen_status(input logic decode_err, input logic slave_err);
    rgen_status_t s;
    s               = '0;
    s[EXOKAY]       = 1'b0;
    s[DECODE_ERROR] = decode_err;
    s[SLAVE_ERROR]  = slave_err;
    return s;
  endfunction

endpackage

// File: rtl/rgen_onehot_mux.sv
// AND-OR selection of one WIDTH-bit slice out of ENTRIES packed slices.
// Latency: purely combinational.
// Backpressure: none; multiple select bits OR their slices together.
module rgen_onehot_mux #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 1
) (
  input  logic [ENTRIES-1:0]       sel_i,
  input  logic [ENTRIES*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]         data_o
);

  // OR together every slice whose select bit is set.
  always_comb begin
    data_o = '0;
    for (int j = 0; j < ENTRIES; j++) begin
      data_o = data_o | (data_i[j*WIDTH +: WIDTH] & {WIDTH{sel_i[j]}});
    end
  end

endmodule

// File: rtl/rgen_response_collector.sv
// Collects one command's response from the register slices; returns data + status.
// Latency: 1 cycle minimum after acceptance, more for wait states, bounded by timeout.
// Backpressure: response held stable until i_response_ready; no new command until after the handshake.
module rgen_response_collector
  import rgen_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_command_valid,
  input  logic                                  i_command_write,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_error,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [DATA_WIDTH-1:0]                 o_read_data,
  output logic [2:0]                            o_status
);

  // Counter only has to reach TIMEOUT_CYCLES-1; it saturates instead of wrapping.
  localparam int CNT_W_RAW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W       = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam int CNT_LAST_I  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rgen_response_state_t  state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  rgen_status_t          status_q, status_d;

  logic                  hit;
  logic                  multi;
  logic                  sel_ready;
  logic                  sel_error;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] cap_data;
  rgen_status_t          cap_status;

  rgen_onehot_mux #(.WIDTH(DATA_WIDTH), .ENTRIES(TOTAL_REGISTERS)) u_data_mux (
    .sel_i  (i_register_select),
    .data_i (i_register_read_data),
    .data_o (sel_data)
  );

  rgen_onehot_mux #(.WIDTH(1), .ENTRIES(TOTAL_REGISTERS)) u_ready_mux (
    .sel_i  (i_register_select),
    .data_i (i_register_ready),
    .data_o (sel_ready)
  );

  // Error only counts when the same slice also signals ready.
  rgen_onehot_mux #(.WIDTH(1), .ENTRIES(TOTAL_REGISTERS)) u_error_mux (
    .sel_i  (i_register_select),
    .data_i (i_register_ready & i_register_error),
    .data_o (sel_error)
  );

  // Decode checks, timeout compare and the response captured on a ready slice.
  always_comb begin
    hit         = |i_register_select;
    multi       = |(i_register_select & (i_register_select - TOTAL_REGISTERS'(1)));
    // cnt_q is zero in IDLE, so TIMEOUT_CYCLES=1 fires in the acceptance cycle.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    cap_status  = rgen_status(1'b0, sel_error);
    cap_data    = (!i_command_write && !sel_error) ? sel_data : '0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (i_command_valid) begin
          if (!hit) begin
            state_d  = RESPOND;
            valid_d  = 1'b1;
            data_d   = '0;
            status_d = rgen_status(1'b1, 1'b0);
          end else if (multi) begin
            state_d  = RESPOND;
            valid_d  = 1'b1;
            data_d   = '0;
            status_d = rgen_status(1'b0, 1'b1);
          end else if (sel_ready) begin
            state_d  = RESPOND;
            valid_d  = 1'b1;
            data_d   = cap_data;
            status_d = cap_status;
          end else if (timeout_hit) begin
            state_d  = RESPOND;
            valid_d  = 1'b1;
            data_d   = '0;
            status_d = rgen_status(1'b0, 1'b1);
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT: begin
        if (!i_command_valid) begin
          // Host withdrew the command: drop it silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sel_ready) begin
          state_d  = RESPOND;
          cnt_d    = '0;
          valid_d  = 1'b1;
          data_d   = cap_data;
          status_d = cap_status;
        end else if (timeout_hit) begin
          state_d  = RESPOND;
          cnt_d    = '0;
          valid_d  = 1'b1;
          data_d   = '0;
          status_d = rgen_status(1'b0, 1'b1);
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESPOND: begin
        if (i_response_ready) begin
          state_d  = IDLE;
          cnt_d    = '0;
          valid_d  = 1'b0;
          data_d   = '0;
          status_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        valid_d  = 1'b0;
        data_d   = '0;
        status_d = '0;
      end
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign o_response_valid = valid_q;
  assign o_read_data      = data_q;
  assign o_status         = status_q;

endmodule

// File: doc/rgen_response_collector.md
Name: rgen_response_collector

Overview:
- Successor to the single-cycle register-block response stage.
- Collects the response for one host command from TOTAL_REGISTERS register slices and returns read data plus a 3-bit status over a valid/ready handshake.
- Adds over the single-cycle stage:
  - per-register wait states (ready);
  - per-register error reporting;
  - a programmable timeout;
  - decode-error and multi-hit detection;
  - host back-pressure.
- Sits between the register-block command decoder and the bus-protocol bridge.

Parameters:
- DATA_WIDTH, 32, width of read data.
- TOTAL_REGISTERS, 1, number of register slices (>=1).
- TIMEOUT_CYCLES, 0, maximum cycles to wait for a selected register's ready. 0 disables the timeout.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_command_valid  input  1  command present. Held, with select, stable until the response handshake or abort.
- i_command_write  input  1  1 = write, 0 = read.
- i_register_select  input  TOTAL_REGISTERS  one-hot register hit vector.
- i_register_ready  input  TOTAL_REGISTERS  per-register access complete.
- i_register_error  input  TOTAL_REGISTERS  per-register access error. Qualified by ready.
- i_register_read_data  input  TOTAL_REGISTERS*DATA_WIDTH  packed read data. Slice j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- o_response_valid  output  1  response available.
- i_response_ready  input  1  host accepts response.
- o_read_data  output  DATA_WIDTH  read data. Zero for writes and errors.
- o_status  output  3  {exokay, decode_error, slave_error}. exokay is always 0.

Behaviour:
- Reset (async, rst_n low):
  - state goes to IDLE;
  - o_response_valid=0, o_read_data=0, o_status=3'b000;
  - timeout counter=0.
  - Reset mid-transaction drops the transaction; no response is issued.
- Derived signals:
  - hit = |select;
  - multi = more than one select bit set;
  - sel_ready = |(select & ready);
  - sel_error = |(select & ready & error);
  - sel_data = AND-OR of the selected slices.
- IDLE state (i_command_valid=1):
  - !hit: go to RESPOND; status 3'b010, data 0.
  - multi: go to RESPOND; status 3'b001, data 0.
  - sel_ready: go to RESPOND; status {0,0,sel_error}; data = sel_data if read and !sel_error, else 0.
  - Otherwise: go to WAIT; counter=1.
  - Minimum latency: o_response_valid asserts the cycle after acceptance.
- WAIT state:
  - sel_ready: go to RESPOND; capture as in IDLE.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: go to RESPOND; status 3'b001, data 0.
  - Else: counter+1.
  - ready and timeout in the same cycle: ready wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It never wraps.
  - i_command_valid low in WAIT: abort to IDLE, no response.
  - Selection change while waiting is a protocol violation; behaviour is undefined.
- RESPOND state:
  - o_response_valid=1; data and status held stable.
  - i_command_valid, ready and error are ignored.
  - On i_response_ready=1: next cycle o_response_valid=0, data=0, status=0, state=IDLE.
  - Back-to-back commands: a new command is accepted no earlier than the cycle after the handshake. Throughput is at most 1 response per 2 cycles.
- Special cases:
  - TIMEOUT_CYCLES=1: no waiting; a non-ready selected register times out in the acceptance cycle.
  - TIMEOUT_CYCLES=0: waits indefinitely.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package rgen_pkg:
  - status bit-position constants (SLAVE_ERROR=0, DECODE_ERROR=1, EXOKAY=2);
  - rgen_status_t (3-bit);
  - state enum rgen_response_state_t {IDLE, WAIT, RESPOND}.
- One sub-module, rgen_onehot_mux (parameters WIDTH, ENTRIES): AND-OR selection of data. Reused for the ready and error reductions with WIDTH=1.

Test Plan (DATA_WIDTH=32, TOTAL_REGISTERS=4, TIMEOUT_CYCLES=8):
- Zero-wait read: read, select=4'b0100, ready[2]=1, data[2]=32'hDEADBEEF, i_response_ready=1 -> valid at cycle+1, data=32'hDEADBEEF, status=3'b000, then valid=0.
- Wait states with back-pressure: read, select=4'b0001, ready[0] rises 3 cycles after acceptance, i_response_ready low 2 cycles -> valid at acceptance+4, held 3 cycles with data/status stable.
- Decode and multi-hit errors:
  - select=4'b0000 -> status 3'b010, data 0.
  - select=4'b0011 -> status 3'b001, data 0.
- Register error and write data masking:
  - write, select=4'b1000, ready[3]=1, error[3]=1 -> status 3'b001, data 0.
  - Same with error=0 -> status 3'b000, data 0.
- Timeout and abort:
  - select=4'b0010, ready never -> valid at acceptance+8, status 3'b001.
  - ready[1] at exactly the 8th cycle -> status 3'b000.
  - Drop command_valid in WAIT -> no response, next command accepted normally.
- Reset in WAIT/RESPOND: rst_n low -> all outputs 0 immediately (async). After release, a normal read completes with latency 1.
